// File: rtl/pc_unit.sv
// Fetch-stage program counter with exception/redirect/stall priority and a
// small circular return-address stack for call/return prediction.
module pc_unit #(
    parameter int unsigned   N         = 32,
    parameter logic [N-1:0]  RESET_VEC = '0,
    parameter logic [31:0]   EXC_VEC   = 32'h0000_0180,
    parameter int unsigned   STEP      = 4,
    parameter int unsigned   RAS_DEPTH = 4,
    parameter int unsigned   RAS_AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              exc,
    input  logic              redirect_en,
    input  logic [N-1:0]      redirect_target,
    input  logic              jump_en,
    input  logic [N-1:0]      jump_target,
    input  logic              call,
    input  logic              ret,
    output logic [N-1:0]      pc,
    output logic [N-1:0]      pc_plus,
    output logic [RAS_AW:0]   ras_count,
    output logic              ras_miss
);

    localparam logic [N-1:0]    EXC_PC  = N'(EXC_VEC);
    localparam logic [N-1:0]    STEP_N  = N'(STEP);
    localparam logic [RAS_AW:0] DEPTH_C = (RAS_AW + 1)'(RAS_DEPTH);
    localparam logic [RAS_AW:0] CNT_ONE = (RAS_AW + 1)'(1);
    localparam logic [RAS_AW-1:0] PTR_ONE = RAS_AW'(1);

    logic [N-1:0]      pc_q,        pc_d;
    logic [RAS_AW-1:0] ras_ptr_q,   ras_ptr_d;
    logic [RAS_AW:0]   ras_count_q, ras_count_d;
    logic              ras_miss_q,  ras_miss_d;

    logic              push_en;
    logic [RAS_AW-1:0] push_idx;
    logic [N-1:0]      ras_top;
    logic              ras_empty;
    logic              take_call;

    // Entry storage carries no reset: validity is tracked by ras_count alone.
    logic [N-1:0]      ras_mem_q [RAS_DEPTH];

    assign pc_plus   = pc_q + STEP_N;
    assign push_idx  = ras_ptr_q + PTR_ONE;
    assign ras_top   = ras_mem_q[ras_ptr_q];
    assign ras_empty = (ras_count_q == '0);
    assign take_call = jump_en & call;

    always_comb begin
        pc_d        = pc_q;
        ras_ptr_d   = ras_ptr_q;
        ras_count_d = ras_count_q;
        ras_miss_d  = 1'b0;
        push_en     = 1'b0;

        if (rst) begin
            pc_d        = RESET_VEC;
            ras_ptr_d   = '0;
            ras_count_d = '0;
        end else if (exc) begin
            pc_d        = EXC_PC;
            ras_ptr_d   = '0;
            ras_count_d = '0;
        end else if (redirect_en) begin
            pc_d = redirect_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (take_call) begin
            // A call beats a simultaneous ret; when full the oldest entry is overwritten.
            pc_d      = jump_target;
            push_en   = 1'b1;
            ras_ptr_d = push_idx;
            if (ras_count_q != DEPTH_C) begin
                ras_count_d = ras_count_q + CNT_ONE;
            end
        end else if (ret) begin
            if (ras_empty) begin
                pc_d       = jump_target;
                ras_miss_d = 1'b1;
            end else begin
                pc_d        = ras_top;
                ras_ptr_d   = ras_ptr_q - PTR_ONE;
                ras_count_d = ras_count_q - CNT_ONE;
            end
        end else if (jump_en) begin
            pc_d = jump_target;
        end else begin
            pc_d = pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            ras_ptr_q   <= '0;
            ras_count_q <= '0;
            ras_miss_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ras_ptr_q   <= ras_ptr_d;
            ras_count_q <= ras_count_d;
            ras_miss_q  <= ras_miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem_q[push_idx] <= pc_plus;
        end
    end

    assign pc        = pc_q;
    assign ras_count = ras_count_q;
    assign ras_miss  = ras_miss_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scenario-driven bench for pc_unit: expected PC/RAS state is queued when
// each cycle's stimulus is applied and compared once the edge has passed.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, exc, redirect_en, jump_en, call, ret;
    logic [31:0] redirect_target, jump_target;
    logic [31:0] pc, pc_plus;
    logic [2:0]  ras_count;
    logic        ras_miss;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        miss;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .exc             (exc),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .jump_en         (jump_en),
        .jump_target     (jump_target),
        .call            (call),
        .ret             (ret),
        .pc              (pc),
        .pc_plus         (pc_plus),
        .ras_count       (ras_count),
        .ras_miss        (ras_miss)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic st, input logic ex, input logic rd,
                         input logic [31:0] rdt, input logic je,
                         input logic [31:0] jt, input logic cl, input logic rt);
        stall = st; exc = ex; redirect_en = rd; redirect_target = rdt;
        jump_en = je; jump_target = jt; call = cl; ret = rt;
    endtask

    task automatic expect_next(input string name, input logic [31:0] p,
                               input logic [2:0] c, input logic m);
        exp_q.push_back('{name, p, c, m});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 1, 32'h55, 1, 0);
        tick();
        expect_next("reset", 32'h0, 3'd0, 1'b0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
            errors++;
            $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                     e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
        end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
            expect_next($sformatf("free%0d", i), 32'(4 * i), 3'd0, 1'b0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
                errors++;
                $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                         e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
            end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        end
    endtask

    task automatic test_call_ret();
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin drive(0, 0, 0, 0, 0, 32'h0,   0, 0); expect_next("cr_seq",  32'h10,  3'd0, 0); end
                1: begin drive(0, 0, 0, 0, 1, 32'h100, 1, 0); expect_next("cr_call", 32'h100, 3'd1, 0); end
                default: begin drive(0, 0, 0, 0, 0, 32'h0, 0, 1); expect_next("cr_ret", 32'h14, 3'd0, 0); end
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
                errors++;
                $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                         e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
            end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        end
    endtask

    task automatic test_ras_overflow();
        for (int s = 0; s < 12; s++) begin
            if (s == 0) begin
                drive(0, 0, 1, 32'h0, 0, 32'h0, 0, 0);
                expect_next("ov_redir", 32'h0, 3'd0, 0);
            end else if (s <= 5) begin
                drive(0, 0, 0, 32'h0, 1, 32'(s * 32'h100), 1, 0);
                expect_next($sformatf("ov_call%0d", s), 32'(s * 32'h100), (s > 4) ? 3'd4 : 3'(s), 0);
            end else if (s <= 9) begin
                drive(0, 0, 0, 32'h0, 0, 32'hDEAD0, 0, 1);
                expect_next($sformatf("ov_ret%0d", s - 5), 32'h404 - 32'((s - 6) * 32'h100), 3'(9 - s), 0);
            end else if (s == 10) begin
                drive(0, 0, 0, 32'h0, 0, 32'h800, 0, 1);
                expect_next("ov_miss", 32'h800, 3'd0, 1);
            end else begin
                drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
                expect_next("ov_after", 32'h804, 3'd0, 0);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
                errors++;
                $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                         e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
            end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        end
    endtask

    task automatic test_stall();
        for (int s = 0; s < 7; s++) begin
            case (s)
                0: begin drive(0, 0, 1, 32'h10, 0, 32'h0,  0, 0); expect_next("st_redir", 32'h10, 3'd0, 0); end
                1: begin drive(0, 0, 0, 32'h0,  1, 32'h20, 1, 0); expect_next("st_call",  32'h20, 3'd1, 0); end
                2, 3, 4: begin
                    drive(1, 0, 0, 32'h0, 1, 32'h300, 1, 0);
                    expect_next($sformatf("st_hold%0d", s - 1), 32'h20, 3'd1, 0);
                end
                5: begin drive(1, 0, 1, 32'h40, 1, 32'h300, 0, 0); expect_next("st_redir_ovr", 32'h40, 3'd1, 0); end
                default: begin drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 1); expect_next("st_ret", 32'h14, 3'd0, 0); end
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
                errors++;
                $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                         e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
            end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        end
    endtask

    task automatic test_exc();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: begin drive(0, 0, 0, 32'h0,   1, 32'h50, 1, 0); expect_next("ex_call1", 32'h50,  3'd1, 0); end
                1: begin drive(0, 0, 0, 32'h0,   1, 32'h60, 1, 0); expect_next("ex_call2", 32'h60,  3'd2, 0); end
                2: begin drive(1, 1, 1, 32'h999, 0, 32'h0,  0, 1); expect_next("ex_take",  32'h180, 3'd0, 0); end
                default: begin drive(0, 0, 0, 32'h0, 0, 32'h700, 0, 1); expect_next("ex_cleared", 32'h700, 3'd0, 1); end
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
                errors++;
                $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                         e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
            end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        end
    endtask

    task automatic test_wrap();
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
                expect_next("wr_top", 32'hFFFF_FFFC, 3'd0, 0);
            end else begin
                drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
                expect_next("wr_zero", 32'h0, 3'd0, 0);
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
                errors++;
                $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                         e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
            end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 7; s++) begin
            case (s)
                0: begin drive(0, 0, 0, 0, 1, 32'h200, 1, 1); expect_next("bb_callret", 32'h200, 3'd1, 0); end
                1: begin drive(0, 0, 0, 0, 0, 32'h0,   1, 1); expect_next("bb_ret_nojmp", 32'h4, 3'd0, 0); end
                2: begin drive(0, 0, 0, 0, 0, 32'h900, 1, 0); expect_next("bb_call_nojmp", 32'h8, 3'd0, 0); end
                3: begin drive(0, 0, 0, 0, 1, 32'h30,  1, 0); expect_next("bb_call1", 32'h30, 3'd1, 0); end
                4: begin drive(0, 0, 0, 0, 1, 32'h70,  1, 0); expect_next("bb_call2", 32'h70, 3'd2, 0); end
                5: begin drive(0, 0, 0, 0, 0, 32'h0,   0, 1); expect_next("bb_ret1",  32'h34, 3'd1, 0); end
                default: begin drive(0, 0, 0, 0, 0, 32'h0, 0, 1); expect_next("bb_ret2", 32'hC, 3'd0, 0); end
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
                errors++;
                $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                         e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
            end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        end
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: begin rst = 0; drive(0, 0, 0, 0, 1, 32'h500, 1, 0); expect_next("rm_call", 32'h500, 3'd1, 0); end
                1: begin rst = 1; drive(0, 1, 1, 32'h77, 1, 32'h600, 1, 0); expect_next("rm_reset", 32'h0, 3'd0, 0); end
                2: begin rst = 0; drive(0, 0, 0, 0, 0, 32'h0, 0, 0); expect_next("rm_seq", 32'h4, 3'd0, 0); end
                default: begin rst = 0; drive(0, 0, 0, 0, 0, 32'h44, 0, 1); expect_next("rm_miss", 32'h44, 3'd0, 1); end
            endcase
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pc, pc_plus, ras_count, ras_miss} !== {e.pc, e.pc + 32'd4, e.cnt, e.miss}) begin
                errors++;
                $display("FAIL %s: pc=%h plus=%h cnt=%0d miss=%b, expected pc=%h cnt=%0d miss=%b",
                         e.name, pc, pc_plus, ras_count, ras_miss, e.pc, e.cnt, e.miss);
            end else $display("txn %s pc=%h cnt=%0d miss=%b", e.name, pc, ras_count, ras_miss);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        test_reset();
        test_free_run();
        test_call_ret();
        test_ras_overflow();
        test_stall();
        test_exc();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
